regfile_dump: RTL and testbench
===============================

# regfile_dump

Debug reader for the 32×32 register unit. On a single-cycle `DumpStart` it walks x0..x31 through a dedicated read port and streams the values as framed bytes over a valid/ready byte interface: a header, 128 little-endian data bytes and an XOR checksum. It sits beside the register unit in the processor top level and drives a UART or debug-link transmitter, so register state can be inspected without halting the pipeline.

## Interface
- `NUM_REGS`, 32, registers dumped, starting at index 0
- `DATA_W`, 32, register width; must be a multiple of 8
- `ADDR_W`, 5, register address width
- `Clk`  in  1  clock; all state changes on the rising edge
- `Rst`  in  1  reset, asynchronous, active-high
- `DumpStart`  in  1  dump request; sampled only in IDLE
- `DumpBusy`  out  1  high in every state except IDLE
- `DumpDone`  out  1  one-cycle pulse at the end of the frame
- `RdAddr`  out  ADDR_W  register read address, connected to a register-unit read port
- `RdData`  in  DATA_W  combinational read data for `RdAddr`
- `ByteOut`  out  8  stream byte
- `ByteValid`  out  1  `ByteOut` is valid
- `ByteReady`  in  1  sink accepts the byte; a transfer occurs when `ByteValid && ByteReady` at a rising edge

## Operation
- States: IDLE, HEADER, LOAD, SEND, CHECK, DONE. The FSM is Moore; all outputs are decoded from registered state and datapath registers.
- IDLE: `ByteValid`=0. If `DumpStart`=1, go to HEADER and clear `RegIdx`, `ByteIdx` and `Csum`.
- HEADER: `ByteOut`=0xA5, `ByteValid`=1. On transfer, go to LOAD.
- LOAD: `ByteValid`=0. Capture `RdData` into `Word` (the read address is `RdAddr`=`RegIdx`), set `ByteIdx`=0, go to SEND. The value captured here is the snapshot: register writes after this cycle do not affect the bytes sent for that register.
- SEND: `ByteOut`=`Word[8*ByteIdx +: 8]`, `ByteValid`=1. On each transfer, `Csum ^= ByteOut`.
  - If `ByteIdx`=DATA_W/8−1 and `RegIdx`=NUM_REGS−1, go to CHECK.
  - If `ByteIdx`=DATA_W/8−1 otherwise, increment `RegIdx` and go to LOAD.
  - Otherwise, increment `ByteIdx`.
- CHECK: `ByteOut`=`Csum`, `ByteValid`=1. On transfer, go to DONE.
- DONE: `DumpDone`=1 for one cycle, then go to IDLE.
- The checksum is the XOR of data bytes only; the header is excluded.
- x0 is not special-cased; it is sent as whatever the register unit returns (0).
- `DumpStart` outside IDLE is ignored. It is not queued.
- Once `ByteValid` rises, `ByteOut` and `ByteValid` hold stable until the transfer. `ByteValid` never drops without a transfer, except on reset.
- `RdAddr`=`RegIdx` at all times.

## Timing
- Reset values: state IDLE, `DumpBusy`=0, `DumpDone`=0, `ByteValid`=0, `ByteOut`=0x00, `RdAddr`=0, `Csum`=0, `Word`=0.
- Asserting `Rst` mid-dump returns the block to IDLE immediately and drops `ByteValid` asynchronously. The partial frame is abandoned; the sink must resynchronise on the 0xA5 header.
- Cycle timing, with `DumpStart` sampled at edge 0 and `ByteReady` held high:
  - HEADER is valid in cycle 1.
  - Register i: LOAD in cycle 2+5i, SEND in cycles 3+5i .. 6+5i.
  - CHECK in cycle 162, DONE in cycle 163, IDLE from cycle 164.
  - `DumpBusy` is high in cycles 1..163.
- Each cycle with `ByteReady`=0 while `ByteValid`=1 extends the frame by exactly one cycle.
- A `DumpStart` held high through DONE starts a new frame on the first IDLE cycle. There is no dead cycle beyond the IDLE visit.

## Structure
- `regfile_dump_pkg`:
  - state enum `dump_state_t`
  - `HEADER_BYTE`=8'hA5
  - default `NUM_REGS`/`DATA_W`/`ADDR_W` localparams shared with the register unit
- Single module; no sub-module. Byte selection and checksum are inline datapath.
- Counters: `RegIdx` is ADDR_W bits; `ByteIdx` is $clog2(DATA_W/8) bits. Neither counter wraps; terminal values are tested explicitly.

## Test plan
- All registers 0, `ByteReady`=1, pulse `DumpStart` → 130 bytes: A5, 128×00, checksum 00. `DumpDone` pulses in cycle 163.
- x1=0x12345678, others 0 → bytes 5–8 are 78 56 34 12, checksum 0x08, all other data bytes 00.
- xi=i for i=0..31, `ByteReady` toggled randomly → byte 1+4i equals i, upper bytes 00, checksum = XOR(0..31)=0x00. `ByteOut` is stable during every stall.
- Write x5=0xDEADBEEF during x4's SEND, then write x5=0 during x5's SEND → the stream carries EF BE AD DE for x5 (snapshot taken at LOAD).
- `DumpStart` pulsed while busy → ignored, a single frame results. `Rst` asserted at byte 40 → `ByteValid`=0 and `DumpBusy`=0 immediately; a new `DumpStart` produces a complete frame starting with A5.

Source files
------------

// File: rtl/regfile_dump_pkg.sv
// Shared types and defaults for the register-file dump reader.
package regfile_dump_pkg;

  // Defaults shared with the 32x32 register unit.
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 5;

  // Frame start marker; the sink resynchronises on this byte.
  localparam logic [7:0] HEADER_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_LOAD,
    S_SEND,
    S_CHECK,
    S_DONE
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_if.sv
// Control, register read port and byte stream of the dump reader.
interface regfile_dump_if
  import regfile_dump_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              DumpStart;
  logic              DumpBusy;
  logic              DumpDone;
  logic [ADDR_W-1:0] RdAddr;
  logic [DATA_W-1:0] RdData;
  logic [7:0]        ByteOut;
  logic              ByteValid;
  logic              ByteReady;

  // Dump engine side.
  modport master (
    input  DumpStart, RdData, ByteReady,
    output DumpBusy, DumpDone, RdAddr, ByteOut, ByteValid
  );

  // Requester / register unit / byte sink side.
  modport slave (
    output DumpStart, RdData, ByteReady,
    input  DumpBusy, DumpDone, RdAddr, ByteOut, ByteValid
  );

endinterface

// File: rtl/regfile_dump.sv
// Walks x0..x(NUM_REGS-1) through a read port and streams a framed dump:
// header 0xA5, little-endian data bytes, XOR checksum of the data bytes.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic           Clk,
  input  logic           Rst,
  regfile_dump_if.master bus
);

  localparam int BYTES = DATA_W / 8;
  localparam int BI_W  = (BYTES > 1) ? $clog2(BYTES) : 1;

  dump_state_t       state_q, state_d;
  logic [ADDR_W-1:0] reg_idx_q, reg_idx_d;
  logic [BI_W-1:0]   byte_idx_q, byte_idx_d;
  logic [7:0]        csum_q, csum_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [7:0]        byte_out_q, byte_out_d;
  logic              byte_valid_q, byte_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              xfer;
  logic              byte_last;
  logic              reg_last;
  logic [7:0]        word_byte;

  assign xfer      = byte_valid_q && bus.ByteReady;
  assign byte_last = (byte_idx_q == BI_W'(BYTES - 1));
  assign reg_last  = (reg_idx_q == ADDR_W'(NUM_REGS - 1));

  // Next state and datapath update.
  always_comb begin
    state_d    = state_q;
    reg_idx_d  = reg_idx_q;
    byte_idx_d = byte_idx_q;
    csum_d     = csum_q;
    word_d     = word_q;
    case (state_q)
      S_IDLE: begin
        if (bus.DumpStart) begin
          state_d    = S_HEADER;
          reg_idx_d  = '0;
          byte_idx_d = '0;
          csum_d     = '0;
        end
      end
      S_HEADER: begin
        if (xfer) state_d = S_LOAD;
      end
      S_LOAD: begin
        word_d     = bus.RdData;
        byte_idx_d = '0;
        state_d    = S_SEND;
      end
      S_SEND: begin
        if (xfer) begin
          csum_d = csum_q ^ byte_out_q;
          if (byte_last) begin
            if (reg_last) begin
              state_d = S_CHECK;
            end else begin
              reg_idx_d = reg_idx_q + 1'b1;
              state_d   = S_LOAD;
            end
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
          end
        end
      end
      S_CHECK: begin
        if (xfer) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Byte lane of the next word selected by the next byte index.
  always_comb begin
    word_byte = '0;
    for (int unsigned b = 0; b < BYTES; b++) begin
      if (byte_idx_d == BI_W'(b)) word_byte = word_d[8*b +: 8];
    end
  end

  // Outputs decoded from the next state so they leave a flop directly;
  // during a stall every input to this decode is unchanged, so the byte holds.
  always_comb begin
    byte_valid_d = 1'b0;
    byte_out_d   = '0;
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
    case (state_d)
      S_HEADER: begin
        byte_valid_d = 1'b1;
        byte_out_d   = HEADER_BYTE;
      end
      S_SEND: begin
        byte_valid_d = 1'b1;
        byte_out_d   = word_byte;
      end
      S_CHECK: begin
        byte_valid_d = 1'b1;
        byte_out_d   = csum_d;
      end
      default: ;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q      <= S_IDLE;
      reg_idx_q    <= '0;
      byte_idx_q   <= '0;
      csum_q       <= '0;
      word_q       <= '0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      reg_idx_q    <= reg_idx_d;
      byte_idx_q   <= byte_idx_d;
      csum_q       <= csum_d;
      word_q       <= word_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.RdAddr    = reg_idx_q;
  assign bus.ByteOut   = byte_out_q;
  assign bus.ByteValid = byte_valid_q;
  assign bus.DumpBusy  = busy_q;
  assign bus.DumpDone  = done_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Directed/randomised bench for regfile_dump with a frame-level reference model.
module tb_regfile_dump;
  import regfile_dump_pkg::*;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  regfile_dump_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  logic [31:0] regs  [32];
  logic [31:0] model [32];
  assign bus.RdData = regs[bus.RdAddr];

  regfile_dump #(.NUM_REGS(32), .DATA_W(32), .ADDR_W(5)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] got   [$];
  logic [7:0] exp_q [$];
  int         done_cycle;
  int         busy_cycles;
  logic       done_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected frame: header, each register little-endian, XOR of data bytes.
  task automatic build_exp();
    logic [7:0] cs;
    logic [7:0] v;
    exp_q = {};
    exp_q.push_back(8'hA5);
    cs = 8'h00;
    for (int r = 0; r < 32; r++) begin
      for (int b = 0; b < 4; b++) begin
        v = 8'((model[r] >> (8 * b)) & 32'hFF);
        exp_q.push_back(v);
        cs = cs ^ v;
      end
    end
    exp_q.push_back(cs);
  endtask

  task automatic cmp_frame(input string name);
    int n;
    chk({name, "_len"}, 32'(got.size()), 32'(exp_q.size()));
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_byte%0d", name, i), 32'(got[i]), 32'(exp_q[i]));
  endtask

  // Runs one frame from a DumpStart pulse; called and returns at a negedge.
  // rdy_pct: ByteReady probability; abort_at: reset after this many bytes;
  // snap: rewrite x5 mid-frame; spur: extra start while busy; hold: keep start high.
  task automatic run_frame(input int rdy_pct, input int abort_at, input bit snap,
                           input bit spur, input bit hold);
    logic       prev_stall;
    logic [7:0] prev_byte;
    got         = {};
    done_cycle  = -1;
    busy_cycles = 0;
    done_seen   = 1'b0;
    prev_stall  = 1'b0;
    prev_byte   = 8'h00;
    bus.DumpStart = 1'b1;
    bus.ByteReady = 1'b0;
    @(negedge Clk);
    if (!hold) bus.DumpStart = 1'b0;
    for (int c = 1; c <= 3000; c++) begin
      if (prev_stall) begin
        chk("stall_valid", 32'(bus.ByteValid), 32'd1);
        chk("stall_byte", 32'(bus.ByteOut), 32'(prev_byte));
      end
      if (c == 1) begin
        chk("hdr_valid", 32'(bus.ByteValid), 32'd1);
        chk("hdr_byte", 32'(bus.ByteOut), 32'hA5);
        chk("hdr_busy", 32'(bus.DumpBusy), 32'd1);
      end
      if (bus.DumpBusy) busy_cycles++;
      if (bus.DumpDone) begin
        done_cycle = c;
        done_seen  = 1'b1;
      end
      if (done_seen && c == done_cycle + 1) begin
        chk("idle_busy", 32'(bus.DumpBusy), 32'd0);
        chk("idle_valid", 32'(bus.ByteValid), 32'd0);
        if (!hold) break;
      end
      if (hold && done_seen && c == done_cycle + 2) begin
        chk("b2b_valid", 32'(bus.ByteValid), 32'd1);
        chk("b2b_byte", 32'(bus.ByteOut), 32'hA5);
        chk("b2b_busy", 32'(bus.DumpBusy), 32'd1);
        bus.DumpStart = 1'b0;
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        return;
      end
      if (snap && got.size() == 18) regs[5] = 32'hDEADBEEF;
      if (snap && got.size() == 23) regs[5] = 32'h0;
      if (abort_at > 0 && got.size() == abort_at) begin
        Rst = 1'b1;
        #1;
        chk("abort_valid", 32'(bus.ByteValid), 32'd0);
        chk("abort_busy", 32'(bus.DumpBusy), 32'd0);
        @(negedge Clk);
        Rst = 1'b0;
        return;
      end
      if (spur && c == 50) bus.DumpStart = 1'b1;
      if (spur && c == 51) bus.DumpStart = 1'b0;
      bus.ByteReady = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < rdy_pct);
      if (bus.ByteValid && bus.ByteReady) got.push_back(bus.ByteOut);
      prev_stall = bus.ByteValid && !bus.ByteReady;
      prev_byte  = bus.ByteOut;
      @(negedge Clk);
    end
    chk("frame_done_seen", 32'(done_seen), 32'd1);
  endtask

  initial begin
    Rst           = 1'b1;
    bus.DumpStart = 1'b0;
    bus.ByteReady = 1'b0;
    for (int i = 0; i < 32; i++) begin
      regs[i]  = 32'h0;
      model[i] = 32'h0;
    end
    repeat (2) @(negedge Clk);
    chk("rst_valid", 32'(bus.ByteValid), 32'd0);
    chk("rst_busy", 32'(bus.DumpBusy), 32'd0);
    chk("rst_done", 32'(bus.DumpDone), 32'd0);
    chk("rst_byte", 32'(bus.ByteOut), 32'h00);
    chk("rst_addr", 32'(bus.RdAddr), 32'd0);
    Rst = 1'b0;
    @(negedge Clk);

    // All zero, ready always high: exact cycle timing.
    build_exp();
    run_frame(100, 0, 1'b0, 1'b0, 1'b0);
    cmp_frame("zero");
    chk("zero_done_cycle", 32'(done_cycle), 32'd163);
    chk("zero_busy_cycles", 32'(busy_cycles), 32'd163);

    // Single non-zero register.
    regs[1]  = 32'h12345678;
    model[1] = 32'h12345678;
    build_exp();
    run_frame(100, 0, 1'b0, 1'b0, 1'b0);
    cmp_frame("x1");
    if (got.size() == 130) begin
      chk("x1_b5", 32'(got[5]), 32'h78);
      chk("x1_b8", 32'(got[8]), 32'h12);
      chk("x1_csum", 32'(got[129]), 32'h08);
    end

    // xi = i with random back-pressure.
    for (int i = 0; i < 32; i++) begin
      regs[i]  = 32'(i);
      model[i] = 32'(i);
    end
    build_exp();
    run_frame(60, 0, 1'b0, 1'b0, 1'b0);
    cmp_frame("idx");

    // Snapshot at LOAD: x5 written before its LOAD, cleared during its SEND.
    for (int i = 0; i < 32; i++) begin
      regs[i]  = 32'h0;
      model[i] = 32'h0;
    end
    model[5] = 32'hDEADBEEF;
    build_exp();
    run_frame(100, 0, 1'b1, 1'b0, 1'b0);
    cmp_frame("snap");

    // Start pulse while busy is ignored.
    for (int i = 0; i < 32; i++) begin
      regs[i]  = $urandom;
      model[i] = regs[i];
    end
    build_exp();
    run_frame(100, 0, 1'b0, 1'b1, 1'b0);
    cmp_frame("spur");
    for (int k = 0; k < 5; k++) begin
      chk("spur_idle", 32'(bus.DumpBusy), 32'd0);
      @(negedge Clk);
    end

    // Reset after byte 40, then a full random frame with random back-pressure.
    run_frame(100, 40, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      regs[i]  = $urandom;
      model[i] = regs[i];
    end
    build_exp();
    run_frame(70, 0, 1'b0, 1'b0, 1'b0);
    cmp_frame("after_rst");

    // Start held through DONE restarts on the first IDLE cycle.
    build_exp();
    run_frame(100, 0, 1'b0, 1'b0, 1'b1);
    cmp_frame("hold");
    chk("hold_rst_valid", 32'(bus.ByteValid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
